// File: rtl/mdu_pkg.sv
// Shared types for the iterative RV32M/RV64M multiply/divide unit.
// Holds the funct3 operation encodings, FSM states and decoded control bundle.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        FINISH
    } mdu_state_e;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic is_div;
        logic want_hi_or_rem;
        logic a_signed;
        logic b_signed;
    } mdu_ctrl_t;

endpackage

// File: rtl/mdu_op_decoder.sv
// Combinational funct3 decode into the control bits used at operand accept.
module mdu_op_decoder
    import mdu_pkg::*;
(
    input  logic [2:0] funct3,
    output mdu_ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (mdu_op_e'(funct3))
            OP_MUL:    ctrl = '{is_div: 1'b0, want_hi_or_rem: 1'b0, a_signed: 1'b0, b_signed: 1'b0};
            OP_MULH:   ctrl = '{is_div: 1'b0, want_hi_or_rem: 1'b1, a_signed: 1'b1, b_signed: 1'b1};
            OP_MULHSU: ctrl = '{is_div: 1'b0, want_hi_or_rem: 1'b1, a_signed: 1'b1, b_signed: 1'b0};
            OP_MULHU:  ctrl = '{is_div: 1'b0, want_hi_or_rem: 1'b1, a_signed: 1'b0, b_signed: 1'b0};
            OP_DIV:    ctrl = '{is_div: 1'b1, want_hi_or_rem: 1'b0, a_signed: 1'b1, b_signed: 1'b1};
            OP_DIVU:   ctrl = '{is_div: 1'b1, want_hi_or_rem: 1'b0, a_signed: 1'b0, b_signed: 1'b0};
            OP_REM:    ctrl = '{is_div: 1'b1, want_hi_or_rem: 1'b1, a_signed: 1'b1, b_signed: 1'b1};
            OP_REMU:   ctrl = '{is_div: 1'b1, want_hi_or_rem: 1'b1, a_signed: 1'b0, b_signed: 1'b0};
            default:   ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Operands are reduced to magnitudes at accept; the sign is applied in FINISH.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_SIGNED = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;       // {hi, lo}: {product hi, multiplier} or {remainder, quotient}
    logic [XLEN-1:0]   opd_q;       // multiplicand or divisor magnitude
    logic              is_div_q, hi_rem_q, neg_q, neg_rem_q, special_q;

    mdu_ctrl_t         ctrl;
    logic              accept;
    logic              sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b, special_val;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] acc_step, prod_s;
    logic [XLEN-1:0]   quo, rem, final_res;

    mdu_op_decoder u_dec (
        .funct3 (funct3),
        .ctrl   (ctrl)
    );

    assign accept = start && !busy && (state_q == IDLE);

    always_comb begin
        sa          = ctrl.a_signed & a[XLEN-1];
        sb          = ctrl.b_signed & b[XLEN-1];
        mag_a       = sa ? -a : a;
        mag_b       = sb ? -b : b;
        div_zero    = ctrl.is_div && (b == '0);
        div_ovf     = ctrl.is_div && ctrl.a_signed && ctrl.b_signed &&
                      (a == MIN_SIGNED) && (b == '1);
        special_val = '0;
        if (div_zero)
            special_val = ctrl.want_hi_or_rem ? a : '1;
        else if (div_ovf)
            special_val = ctrl.want_hi_or_rem ? '0 : MIN_SIGNED;
    end

    // One iteration of either algorithm; the LSB of acc selects the add for multiply.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opd_q};
        if (!is_div_q)
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        else if (!div_trial[XLEN])
            acc_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            acc_step = {acc_q[2*XLEN-2:0], 1'b0};
    end

    always_comb begin
        prod_s    = neg_q ? -acc_q : acc_q;
        quo       = acc_q[XLEN-1:0];
        rem       = acc_q[2*XLEN-1:XLEN];
        final_res = '0;
        if (special_q)
            final_res = acc_q[XLEN-1:0];
        else if (is_div_q)
            final_res = hi_rem_q ? (neg_rem_q ? -rem : rem) : (neg_q ? -quo : quo);
        else
            final_res = hi_rem_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (div_zero || div_ovf) ? FIX : CALC;
            CALC:    if (cnt_q == CNT_LAST) state_d = FINISH;
            FIX:     state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt_q  <= '0;
        end else begin
            done <= (state_q == FINISH);
            if (accept)    busy <= 1'b1;
            else if (done) busy <= 1'b0;
            if (accept)                 cnt_q <= '0;
            else if (state_q == CALC)   cnt_q <= cnt_q + 1'b1;
            if (state_q == FINISH)      result <= final_res;
        end
    end

    // Datapath captures private copies of everything at accept; inputs are not read again.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div_q  <= ctrl.is_div;
            hi_rem_q  <= ctrl.want_hi_or_rem;
            special_q <= div_zero || div_ovf;
            neg_q     <= sa ^ sb;
            neg_rem_q <= sa;
            if (div_zero || div_ovf) begin
                acc_q <= {{XLEN{1'b0}}, special_val};
                opd_q <= mag_b;
            end else if (ctrl.is_div) begin
                acc_q <= {{XLEN{1'b0}}, mag_a};
                opd_q <= mag_b;
            end else begin
                acc_q <= {{XLEN{1'b0}}, mag_b};
                opd_q <= mag_a;
            end
        end else if (state_q == CALC) begin
            acc_q <= acc_step;
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: XLEN=32 directed cases plus an XLEN=8 random sweep,
// both scored against an arithmetic reference model with per-cycle checks.
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        rst32, start32, busy32, done32;
    logic [2:0]  f3_32;
    logic [31:0] a32, b32, result32;
    logic        rst8, start8, busy8, done8;
    logic [2:0]  f3_8;
    logic [7:0]  a8, b8, result8;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] res;
        longint      due;
    } exp_t;

    exp_t        q32[$], q8[$];
    bit          pop32 = 0, pop8 = 0, armed32 = 0, armed8 = 0;
    logic [31:0] held32 = '0, held8 = '0;
    longint      cyc = 0;

    always #5 clk = ~clk;

    mdu_iterative #(.XLEN(32)) dut32 (
        .clk(clk), .reset(rst32), .start(start32), .funct3(f3_32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(result32)
    );

    mdu_iterative #(.XLEN(8)) dut8 (
        .clk(clk), .reset(rst8), .start(start8), .funct3(f3_8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint zx(input int w, input logic [31:0] v);
        longint u;
        u = longint'({32'd0, v});
        if (w < 32) u = u & ((64'sd1 << w) - 1);
        return u;
    endfunction

    function automatic longint sx(input int w, input logic [31:0] v);
        longint u;
        u = zx(w, v);
        if (u >= (64'sd1 << (w - 1))) u = u - (64'sd1 << w);
        return u;
    endfunction

    function automatic logic [31:0] ref_op(input int w, input logic [2:0] f3,
                                           input logic [31:0] av, input logic [31:0] bv);
        longint ua, ub, sa, sb, minv;
        logic signed [127:0] x, y, p;
        logic [63:0] r;
        logic [31:0] m;
        m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        ua   = zx(w, av);  ub = zx(w, bv);
        sa   = sx(w, av);  sb = sx(w, bv);
        minv = -(64'sd1 << (w - 1));
        r    = '0;
        case (f3)
            3'd0: begin x = sa; y = sb; p = x * y;          r = p[63:0]; end
            3'd1: begin x = sa; y = sb; p = (x * y) >>> w;  r = p[63:0]; end
            3'd2: begin x = sa; y = ub; p = (x * y) >>> w;  r = p[63:0]; end
            3'd3: begin x = ua; y = ub; p = (x * y) >>> w;  r = p[63:0]; end
            3'd4: if (ub == 0) r = '1; else if (sa == minv && sb == -1) r = sa; else r = sa / sb;
            3'd5: if (ub == 0) r = '1; else r = ua / ub;
            3'd6: if (ub == 0) r = ua; else if (sa == minv && sb == -1) r = 0; else r = sa % sb;
            default: if (ub == 0) r = ua; else r = ua % ub;
        endcase
        return r[31:0] & m;
    endfunction

    function automatic int ref_lat(input int w, input logic [2:0] f3,
                                   input logic [31:0] av, input logic [31:0] bv);
        if (f3[2] && (zx(w, bv) == 0 ||
            (!f3[0] && sx(w, av) == -(64'sd1 << (w - 1)) && sx(w, bv) == -1)))
            return 2;
        return w + 1;
    endfunction

    // Model side: cycle count, accept decisions and retirement of finished ops.
    always @(posedge clk) begin
        cyc++;
        if (rst32) begin
            q32.delete(); pop32 = 0; held32 = '0; armed32 = 1;
        end else begin
            if (start32 && q32.size() == 0)
                q32.push_back('{ref_op(32, f3_32, a32, b32), cyc + ref_lat(32, f3_32, a32, b32)});
            if (pop32) begin q32.delete(0); pop32 = 0; end
        end
        if (rst8) begin
            q8.delete(); pop8 = 0; held8 = '0; armed8 = 1;
        end else begin
            if (start8 && q8.size() == 0)
                q8.push_back('{ref_op(8, f3_8, {24'd0, a8}, {24'd0, b8}),
                               cyc + ref_lat(8, f3_8, {24'd0, a8}, {24'd0, b8})});
            if (pop8) begin q8.delete(0); pop8 = 0; end
        end
    end

    always @(negedge clk) begin
        logic eb, ed;
        if (armed32) begin
            eb = (q32.size() != 0);
            ed = 1'b0;
            if (eb) ed = (q32[0].due == cyc);
            check("busy32", {31'd0, busy32}, {31'd0, eb});
            check("done32", {31'd0, done32}, {31'd0, ed});
            if (ed) begin
                check("result32", result32, q32[0].res);
                held32 = q32[0].res; pop32 = 1;
            end else check("hold32", result32, held32);
        end
        if (armed8) begin
            eb = (q8.size() != 0);
            ed = 1'b0;
            if (eb) ed = (q8[0].due == cyc);
            check("busy8", {31'd0, busy8}, {31'd0, eb});
            check("done8", {31'd0, done8}, {31'd0, ed});
            if (ed) begin
                check("result8", {24'd0, result8}, q8[0].res);
                held8 = q8[0].res; pop8 = 1;
            end else check("hold8", {24'd0, result8}, held8);
        end
    end

    task automatic run32(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_res, input int exp_lat, input string nm);
        int n;
        bit seen;
        n = 0;
        while (busy32 && n < 200) begin @(posedge clk); #1; n++; end
        start32 = 1'b1; f3_32 = f3; a32 = av; b32 = bv;
        @(posedge clk); #1;
        start32 = 1'b0; a32 = $urandom; b32 = $urandom; f3_32 = 3'($urandom);
        n = 0; seen = 0;
        while (!seen && n < 200) begin
            @(posedge clk); #1; n++;
            if (done32) seen = 1;
        end
        check({nm, "_lat"}, 32'(n), 32'(exp_lat));
        check(nm, result32, exp_res);
    endtask

    task automatic directed32();
        int n;
        bit seen;
        run32(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7x-3");
        run32(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min");
        run32(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max");
        run32(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
        run32(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_-7/2");
        run32(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_-7/2");
        run32(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu_100/7");
        run32(3'b111, 32'd100, 32'd7, 32'd2, 33, "remu_100/7");
        run32(3'b100, 32'd42, 32'd0, 32'hFFFF_FFFF, 2, "div_by0");
        run32(3'b110, 32'd42, 32'd0, 32'd42, 2, "rem_by0");
        run32(3'b101, 32'd42, 32'd0, 32'hFFFF_FFFF, 2, "divu_by0");
        run32(3'b111, 32'd5, 32'd0, 32'd5, 2, "remu_by0");
        run32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_ovf");
        run32(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, "rem_ovf");
        run32(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "divu_noovf");

        // start held high for a whole op while operands churn
        n = 0;
        while (busy32 && n < 200) begin @(posedge clk); #1; n++; end
        start32 = 1'b1; f3_32 = 3'b101; a32 = 32'd1000; b32 = 32'd9;
        @(posedge clk); #1;
        n = 0; seen = 0;
        while (!seen && n < 200) begin
            a32 = $urandom; b32 = $urandom;
            @(posedge clk); #1; n++;
            if (done32) seen = 1;
        end
        check("stream_lat", 32'(n), 32'd33);
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("stream_hold", result32, 32'd111);

        // reset ten cycles into an op aborts it silently
        run32(3'b000, 32'd3, 32'd5, 32'd15, 33, "mul_3x5");
        @(posedge clk); #1;
        start32 = 1'b1; f3_32 = 3'b000; a32 = 32'd9; b32 = 32'd9;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst32 = 1'b1;
        @(posedge clk); #1;
        rst32 = 1'b0;
        check("rst_busy", {31'd0, busy32}, 32'd0);
        check("rst_done", {31'd0, done32}, 32'd0);
        check("rst_result", result32, 32'd0);
        repeat (40) @(posedge clk);
        #1 check("rst_result_later", result32, 32'd0);

        // back-to-back random ops with edge-case bias
        start32 = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            f3_32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
            case ($urandom_range(0, 7))
                0: b32 = '0;
                1: begin a32 = 32'h8000_0000; b32 = '1; end
                2: b32 = 32'($urandom_range(1, 15));
                default: ;
            endcase
            @(posedge clk); #1;
        end
        start32 = 1'b0;
    endtask

    task automatic sweep8();
        start8 = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            f3_8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            case ($urandom_range(0, 7))
                0: b8 = '0;
                1: begin a8 = 8'h80; b8 = 8'hFF; end
                2: b8 = 8'($urandom_range(1, 3));
                default: ;
            endcase
            rst8 = (i == 2000);
            @(posedge clk); #1;
        end
        rst8 = 1'b0;
        start8 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst32 = 1'b1; rst8 = 1'b1;
        start32 = 1'b0; start8 = 1'b0;
        f3_32 = '0; a32 = '0; b32 = '0;
        f3_8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst32 = 1'b0; rst8 = 1'b0;
        check("reset_busy", {31'd0, busy32}, 32'd0);
        check("reset_done", {31'd0, done32}, 32'd0);
        check("reset_result", result32, 32'd0);
        fork
            directed32();
            sweep8();
        join
        repeat (80) @(posedge clk);
        #1;
        check("drain32", 32'(q32.size()), 32'd0);
        check("drain8", 32'(q8.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
